// File: rtl/cmp_pkg.sv
// Shared types and defaults for the comparator capture block.
//   cmp_cap_state_t   : capture FSM state encoding
//   CMP_NVOTE_DEFAULT : default decisions per result
//   CMP_CW_DEFAULT    : ones-count width matching the default vote size
package cmp_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } cmp_cap_state_t;

  localparam int unsigned CMP_NVOTE_DEFAULT = 4;
  localparam int unsigned CMP_CW_DEFAULT    = $clog2(CMP_NVOTE_DEFAULT + 1);

endpackage : cmp_pkg

// File: rtl/cmp_sync.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
//   clk   : destination clock
//   reset : synchronous active-high reset, clears both flops to 0
//   d     : asynchronous input
//   q     : synchronized output, 2 cycles after d
module cmp_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Metastability filter chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : cmp_sync

// File: rtl/cmp_capture.sv
// Captures NVOTE comparator decisions per conversion and presents a majority
// vote plus ones count over a valid/ready handshake.
//   clk, reset        : clock, synchronous active-high reset
//   cmp_p1, cmp_p2    : sequencer evaluate / precharge phases
//   zero              : sequencer zero request (level)
//   sample            : sample strobe, rising edge is a decision event
//   cmp_out           : asynchronous comparator decision
//   result, ones_cnt  : majority decision and number of 1 decisions
//   valid, ready      : result handshake
//   phase_err         : sticky, event seen with cmp_p1 == cmp_p2
//   overrun           : sticky, event seen while holding an unaccepted result
module cmp_capture
  import cmp_pkg::*;
#(
  parameter int unsigned NVOTE = CMP_NVOTE_DEFAULT,
  parameter int unsigned CW    = $clog2(NVOTE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmp_p1,
  input  logic          cmp_p2,
  input  logic          zero,
  input  logic          sample,
  input  logic          cmp_out,
  output logic          result,
  output logic [CW-1:0] ones_cnt,
  output logic          valid,
  input  logic          ready,
  output logic          phase_err,
  output logic          overrun
);

  cmp_cap_state_t r_state;
  cmp_cap_state_t w_state_nxt;

  logic          r_sample_q;
  logic [CW-1:0] r_acc;
  logic [CW-1:0] r_dec_cnt;
  logic          r_result;
  logic [CW-1:0] r_ones_cnt;
  logic          r_valid;
  logic          r_phase_err;
  logic          r_overrun;

  logic [CW-1:0] w_acc_nxt;
  logic [CW-1:0] w_dec_cnt_nxt;
  logic          w_result_nxt;
  logic [CW-1:0] w_ones_cnt_nxt;
  logic          w_valid_nxt;
  logic          w_phase_err_nxt;
  logic          w_overrun_nxt;

  logic w_cmp_s;
  logic w_event;
  logic w_evt_eval;
  logic w_evt_bad;
  logic w_full;
  logic w_xfer;

  cmp_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cmp_out),
    .q     (w_cmp_s)
  );

  // Event qualification: rising edge of sample, split by sequencer phase.
  assign w_event    = sample & ~r_sample_q;
  assign w_evt_eval = w_event & cmp_p1 & ~cmp_p2;
  assign w_evt_bad  = w_event & (cmp_p1 == cmp_p2);
  assign w_full     = (r_dec_cnt == CW'(NVOTE));
  assign w_xfer     = r_valid & ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ZERO;
      r_sample_q  <= 1'b0;
      r_acc       <= '0;
      r_dec_cnt   <= '0;
      r_result    <= 1'b0;
      r_ones_cnt  <= '0;
      r_valid     <= 1'b0;
      r_phase_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sample_q  <= sample;
      r_acc       <= w_acc_nxt;
      r_dec_cnt   <= w_dec_cnt_nxt;
      r_result    <= w_result_nxt;
      r_ones_cnt  <= w_ones_cnt_nxt;
      r_valid     <= w_valid_nxt;
      r_phase_err <= w_phase_err_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  // Next-state logic. The full window is recognised one cycle after the last
  // event, so the outputs latch from the already-updated accumulator.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ZERO: begin
        if (!zero) w_state_nxt = ACCUM;
      end
      ACCUM: begin
        if (zero)        w_state_nxt = ZERO;
        else if (w_full) w_state_nxt = HOLD;
      end
      HOLD: begin
        // zero is only honoured once the pending result has been taken
        if (w_xfer) w_state_nxt = zero ? ZERO : ACCUM;
      end
      default: w_state_nxt = ZERO;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    w_acc_nxt       = r_acc;
    w_dec_cnt_nxt   = r_dec_cnt;
    w_result_nxt    = r_result;
    w_ones_cnt_nxt  = r_ones_cnt;
    w_valid_nxt     = r_valid;
    w_phase_err_nxt = r_phase_err | w_evt_bad;
    w_overrun_nxt   = r_overrun;
    unique case (r_state)
      ZERO: begin
        w_acc_nxt     = '0;
        w_dec_cnt_nxt = '0;
      end
      ACCUM: begin
        if (zero) begin
          w_acc_nxt     = '0;
          w_dec_cnt_nxt = '0;
        end else if (w_full) begin
          // strict majority: a tie resolves to 0
          w_result_nxt   = (r_acc > CW'(NVOTE / 2));
          w_ones_cnt_nxt = r_acc;
          w_valid_nxt    = 1'b1;
        end else if (w_evt_eval) begin
          w_dec_cnt_nxt = r_dec_cnt + CW'(1);
          w_acc_nxt     = r_acc + CW'(w_cmp_s);
        end
      end
      HOLD: begin
        // any event here, including one coincident with the transfer, is lost
        w_overrun_nxt = r_overrun | w_event;
        if (w_xfer) begin
          w_valid_nxt   = 1'b0;
          w_acc_nxt     = '0;
          w_dec_cnt_nxt = '0;
        end
      end
      default: begin
        w_acc_nxt     = '0;
        w_dec_cnt_nxt = '0;
        w_valid_nxt   = 1'b0;
      end
    endcase
  end

  assign result    = r_result;
  assign ones_cnt  = r_ones_cnt;
  assign valid     = r_valid;
  assign phase_err = r_phase_err;
  assign overrun   = r_overrun;

endmodule : cmp_capture

// File: tb/tb_cmp_capture.sv
// Bench for cmp_capture: randomized decisions against a window-level model.
module tb_cmp_capture;

  localparam int unsigned NV = 4;
  localparam int unsigned CW = $clog2(NV + 1);

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          cmp_p1  = 1'b0;
  logic          cmp_p2  = 1'b0;
  logic          zero    = 1'b1;
  logic          sample  = 1'b0;
  logic          cmp_out = 1'b0;
  logic          ready   = 1'b0;
  logic          result;
  logic [CW-1:0] ones_cnt;
  logic          valid;
  logic          phase_err;
  logic          overrun;

  int total = 0;
  int bad   = 0;

  // Model: accepted decisions of the current window plus the pending result.
  bit win_q[$];
  bit m_hold = 1'b0;
  bit m_perr = 1'b0;
  bit m_ovr  = 1'b0;
  int m_ones = 0;
  bit m_res  = 1'b0;

  always #5 clk = ~clk;

  cmp_capture #(.NVOTE(NV), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmp_p1    (cmp_p1),
    .cmp_p2    (cmp_p2),
    .zero      (zero),
    .sample    (sample),
    .cmp_out   (cmp_out),
    .result    (result),
    .ones_cnt  (ones_cnt),
    .valid     (valid),
    .ready     (ready),
    .phase_err (phase_err),
    .overrun   (overrun)
  );

  // One sample pulse with cmp_out settled 3 cycles ahead; v_at_t is valid
  // seen right after the event edge. Updates the model.
  task automatic send_event(input logic p1, input logic p2, input logic b,
                            output logic v_at_t);
    cmp_out = b;
    cmp_p1  = p1;
    cmp_p2  = p2;
    repeat (3) @(negedge clk);
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    v_at_t = valid;
    if (p1 == p2) m_perr = 1'b1;
    if (m_hold) m_ovr = 1'b1;
    else if (!zero && p1 && !p2) begin
      win_q.push_back(b);
      if (win_q.size() == int'(NV)) begin
        m_hold = 1'b1;
        m_ones = 0;
        foreach (win_q[i]) m_ones += int'(win_q[i]);
        m_res = (m_ones > int'(NV / 2));
      end
    end
    @(negedge clk);
  endtask

  task automatic accept();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    if (m_hold) begin
      m_hold = 1'b0;
      win_q.delete();
    end
  endtask

  task automatic fill_random();
    logic v;
    for (int i = 0; i < int'(NV); i++) send_event(1'b1, 1'b0, 1'($urandom_range(0, 1)), v);
  endtask

  task automatic test_reset();
    reset = 1'b1; ready = 1'b0; sample = 1'b0; zero = 1'b1;
    cmp_p1 = 1'b0; cmp_p2 = 1'b0; cmp_out = 1'b0;
    repeat (2) @(negedge clk);
    m_hold = 1'b0; m_perr = 1'b0; m_ovr = 1'b0; win_q.delete();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (result !== 1'b0) begin bad++; $display("FAIL reset_result got=%b want=0", result); end
    total++; if (ones_cnt !== '0) begin bad++; $display("FAIL reset_ones got=%0d want=0", ones_cnt); end
    total++; if (phase_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", phase_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", overrun); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic v;
    zero = 1'b0;
    @(negedge clk);
    send_event(1'b1, 1'b0, 1'b1, v);
    send_event(1'b1, 1'b0, 1'b1, v);
    send_event(1'b1, 1'b0, 1'b0, v);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%b want=0", valid); end
    send_event(1'b1, 1'b0, 1'b1, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL basic_latency got=%b want=0", v); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", valid); end
    total++; if (result !== 1'b1) begin bad++; $display("FAIL basic_result got=%b want=1", result); end
    total++; if (ones_cnt !== CW'(3)) begin bad++; $display("FAIL basic_ones got=%0d want=3", ones_cnt); end
    accept();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_accept got=%b want=0", valid); end
  endtask

  task automatic test_patterns();
    logic v;
    logic [3:0] pats [2];
    logic [3:0] p;
    pats[0] = 4'b1010;
    pats[1] = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      if (k < 2) begin
        p = pats[k];
        for (int i = 3; i >= 0; i--) send_event(1'b1, 1'b0, p[i], v);
      end else begin
        for (int i = 0; i < int'(NV); i++) begin
          if ($urandom_range(0, 2) == 0) send_event(1'b0, 1'b1, 1'($urandom_range(0, 1)), v);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send_event(1'b1, 1'b0, 1'($urandom_range(0, 1)), v);
        end
      end
      total++; if (valid !== m_hold) begin bad++; $display("FAIL pat%0d_valid got=%b want=%b", k, valid, m_hold); end
      total++; if (result !== m_res) begin bad++; $display("FAIL pat%0d_result got=%b want=%b", k, result, m_res); end
      total++; if (ones_cnt !== CW'(m_ones)) begin bad++; $display("FAIL pat%0d_ones got=%0d want=%0d", k, ones_cnt, m_ones); end
      accept();
    end
  endtask

  task automatic test_phase();
    logic v;
    send_event(1'b1, 1'b0, 1'b1, v);
    send_event(1'b1, 1'b0, 1'b0, v);
    send_event(1'b1, 1'b1, 1'b1, v);
    total++; if (phase_err !== m_perr) begin bad++; $display("FAIL phase_err got=%b want=%b", phase_err, m_perr); end
    send_event(1'b0, 1'b1, 1'b1, v);
    send_event(1'b0, 1'b0, 1'b1, v);
    send_event(1'b1, 1'b0, 1'b1, v);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL phase_count got=%b want=0", valid); end
    send_event(1'b1, 1'b0, 1'($urandom_range(0, 1)), v);
    total++; if (valid !== m_hold) begin bad++; $display("FAIL phase_valid got=%b want=%b", valid, m_hold); end
    total++; if (ones_cnt !== CW'(m_ones)) begin bad++; $display("FAIL phase_ones got=%0d want=%0d", ones_cnt, m_ones); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL phase_ovr got=%b want=0", overrun); end
    accept();
  endtask

  task automatic test_zero();
    logic v;
    send_event(1'b1, 1'b0, 1'b1, v);
    send_event(1'b1, 1'b0, 1'b1, v);
    zero = 1'b1;
    @(negedge clk);
    zero = 1'b0;
    win_q.delete();
    for (int i = 0; i < 3; i++) send_event(1'b1, 1'b0, 1'($urandom_range(0, 1)), v);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL zero_discard got=%b want=0", valid); end
    send_event(1'b1, 1'b0, 1'($urandom_range(0, 1)), v);
    total++; if (result !== m_res) begin bad++; $display("FAIL zero_result got=%b want=%b", result, m_res); end
    total++; if (ones_cnt !== CW'(m_ones)) begin bad++; $display("FAIL zero_ones got=%0d want=%0d", ones_cnt, m_ones); end
    zero = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL zero_hold got=%b want=1", valid); end
    total++; if (ones_cnt !== CW'(m_ones)) begin bad++; $display("FAIL zero_hold_ones got=%0d want=%0d", ones_cnt, m_ones); end
    accept();
    send_event(1'b1, 1'b0, 1'b1, v);
    total++; if (overrun !== m_ovr) begin bad++; $display("FAIL zero_state_ovr got=%b want=%b", overrun, m_ovr); end
    zero = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) send_event(1'b1, 1'b0, 1'($urandom_range(0, 1)), v);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL zero_state_cnt got=%b want=0", valid); end
    send_event(1'b1, 1'b0, 1'($urandom_range(0, 1)), v);
    total++; if (ones_cnt !== CW'(m_ones)) begin bad++; $display("FAIL zero_after_ones got=%0d want=%0d", ones_cnt, m_ones); end
    accept();
  endtask

  task automatic test_back_to_back();
    fill_random();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_pre_ovr got=%b want=0", overrun); end
    cmp_out = 1'b1; cmp_p1 = 1'b1; cmp_p2 = 1'b0;
    repeat (3) @(negedge clk);
    ready = 1'b1;
    sample = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    sample = 1'b0;
    m_ovr = 1'b1; m_hold = 1'b0; win_q.delete();
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%b want=0", valid); end
    total++; if (overrun !== m_ovr) begin bad++; $display("FAIL b2b_ovr got=%b want=%b", overrun, m_ovr); end
    fill_random();
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL b2b_fresh_valid got=%b want=1", valid); end
    total++; if (ones_cnt !== CW'(m_ones)) begin bad++; $display("FAIL b2b_fresh_ones got=%0d want=%0d", ones_cnt, m_ones); end
    accept();
  endtask

  task automatic test_overrun();
    logic v;
    fill_random();
    for (int k = 0; k < 2; k++) begin
      send_event(1'b1, 1'b0, 1'($urandom_range(0, 1)), v);
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL ovr%0d_valid got=%b want=1", k, valid); end
      total++; if (result !== m_res) begin bad++; $display("FAIL ovr%0d_result got=%b want=%b", k, result, m_res); end
      total++; if (ones_cnt !== CW'(m_ones)) begin bad++; $display("FAIL ovr%0d_ones got=%0d want=%0d", k, ones_cnt, m_ones); end
      total++; if (overrun !== m_ovr) begin bad++; $display("FAIL ovr%0d_flag got=%b want=%b", k, overrun, m_ovr); end
    end
    accept();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ovr_accept got=%b want=0", valid); end
    fill_random();
    total++; if (result !== m_res) begin bad++; $display("FAIL ovr_fresh_result got=%b want=%b", result, m_res); end
    total++; if (ones_cnt !== CW'(m_ones)) begin bad++; $display("FAIL ovr_fresh_ones got=%0d want=%0d", ones_cnt, m_ones); end
    accept();
  endtask

  task automatic test_reset_hold();
    fill_random();
    cmp_out = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid got=%b want=0", valid); end
    total++; if (ones_cnt !== '0) begin bad++; $display("FAIL rst_hold_ones got=%0d want=0", ones_cnt); end
    total++; if (phase_err !== 1'b0) begin bad++; $display("FAIL rst_hold_perr got=%b want=0", phase_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_hold_ovr got=%b want=0", overrun); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_phase();
    test_zero();
    test_reset();
    zero = 1'b0;
    @(negedge clk);
    test_back_to_back();
    test_overrun();
    test_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cmp_capture
